// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the byte-writable SRAM and its clear sequencer
package sram_pkg;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;
    localparam int BYTE_W = 8;
    function automatic int num_lanes(input int dw);
        return dw / BYTE_W;
    endfunction
    // even parity: stored bit makes the lane plus parity have an even number of ones
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/sram_bw_if.sv
// sram_bw_if: access port bundle for sram_bw; parity_err exists only with SRAM_PARITY_EN
interface sram_bw_if
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    localparam int NB = num_lanes(DATA_WIDTH);
    logic                  ce;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  ready;
    logic                  addr_err;
`ifdef SRAM_PARITY_EN
    logic                  parity_err;
`endif
    modport master (
        output ce, we, be, addr, wdata,
        input  rdata, rvalid, ready, addr_err
`ifdef SRAM_PARITY_EN
        , parity_err
`endif
    );
    modport slave (
        input  ce, we, be, addr, wdata,
        output rdata, rvalid, ready, addr_err
`ifdef SRAM_PARITY_EN
        , parity_err
`endif
    );
endinterface

// File: rtl/sram_clear_seq.sv
// sram_clear_seq: post-reset FSM that zeroes every word once, then raises ready
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int DEPTH          = 8192,
    parameter int ADDR_WIDTH     = 13,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    state_e                state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == ST_CLEAR) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = cnt == LAST ? ST_IDLE : ST_CLEAR;
        end
    end
    // rst gates both outputs so nothing is accepted or cleared during the reset cycle itself
    assign ready    = state == ST_IDLE && !rst;
    assign clr_we   = state == ST_CLEAR && !rst;
    assign clr_addr = cnt;
endmodule

// File: rtl/sram_bw.sv
// sram_bw: single-port SRAM with byte enables, clear-on-reset, read latency 1 or 2 and range check.
// Define SRAM_PARITY_EN to store one even-parity bit per lane and raise parity_err on bad reads.
module sram_bw
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 8192,
    parameter int ADDR_WIDTH     = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic      clk,
    input logic      rst,
    sram_bw_if.slave bus
);
    localparam int NB = num_lanes(DATA_WIDTH);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef SRAM_PARITY_EN
    localparam int MW = DATA_WIDTH + NB;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    if (DATA_WIDTH < BYTE_W || DATA_WIDTH % BYTE_W != 0) begin : g_bad_dw
        $error("sram_bw: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || ADDR_WIDTH < IW) begin : g_bad_aw
        $error("sram_bw: ADDR_WIDTH too small for DEPTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_rl
        $error("sram_bw: READ_LATENCY must be 1 or 2");
    end

    logic                  ready, clr_we;
    logic [IW-1:0]         clr_addr, idx;
    logic                  in_range, rd_acc, wr_acc, wr_en;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data, rd1, rd2;
    logic [MW-1:0]         mem [DEPTH];
    logic [MW-1:0]         word;
    logic                  rv1, rv2, re1, re2, we1;

    sram_clear_seq #(
        .DEPTH(DEPTH),
        .ADDR_WIDTH(IW),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear (
        .clk(clk),
        .rst(rst),
        .ready(ready),
        .clr_we(clr_we),
        .clr_addr(clr_addr)
    );

    // the clear sequencer and the user port share the single array port
    assign in_range = {1'b0, bus.addr} < DEPTH_L;
    assign rd_acc   = bus.ce & ready & ~bus.we;
    assign wr_acc   = bus.ce & ready & bus.we;
    assign wr_en    = clr_we | (wr_acc & in_range);
    assign idx      = clr_we ? clr_addr : bus.addr[IW-1:0];
    assign wr_be    = clr_we ? '1 : bus.be;
    assign wr_data  = clr_we ? '0 : bus.wdata;
    assign word     = mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[idx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
`ifdef SRAM_PARITY_EN
                    mem[idx][DATA_WIDTH+i] <= byte_parity(wr_data[i*BYTE_W +: BYTE_W]);
`endif
                end
            end
        end
    end

    // stage 1 is the array output register; stage 2 is used only when READ_LATENCY is 2
    always_ff @(posedge clk) begin
        if (rst) begin
            rv1 <= 1'b0;
            re1 <= 1'b0;
            we1 <= 1'b0;
            rd1 <= '0;
            rv2 <= 1'b0;
            re2 <= 1'b0;
            rd2 <= '0;
        end else begin
            rv1 <= rd_acc;
            re1 <= rd_acc & ~in_range;
            we1 <= wr_acc & ~in_range;
            if (rd_acc) rd1 <= in_range ? word[DATA_WIDTH-1:0] : '0;
            rv2 <= rv1;
            re2 <= re1;
            if (rv1) rd2 <= rd1;
        end
    end

    assign bus.ready    = ready;
    assign bus.rvalid   = READ_LATENCY == 2 ? rv2 : rv1;
    assign bus.rdata    = READ_LATENCY == 2 ? rd2 : rd1;
    assign bus.addr_err = (READ_LATENCY == 2 ? re2 : re1) | we1;

`ifdef SRAM_PARITY_EN
    logic par_bad, pe1, pe2;
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++)
            par_bad = par_bad | (word[DATA_WIDTH+i] != byte_parity(word[i*BYTE_W +: BYTE_W]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pe1 <= 1'b0;
            pe2 <= 1'b0;
        end else begin
            pe1 <= rd_acc & in_range & par_bad;
            pe2 <= pe1;
        end
    end
    assign bus.parity_err = READ_LATENCY == 2 ? pe2 : pe1;
`endif
endmodule

// File: tb/tb_sram_bw.sv
// tb_sram_bw: two sram_bw instances (DEPTH 16 / latency 1, DEPTH 12 / latency 2) on shared stimulus,
// checked every cycle against a word-array model with a latency delay line.
module tb_sram_bw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ce, we;
    logic [3:0]  be, a4;
    logic [31:0] wd;

    sram_bw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) ia ();
    sram_bw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) ib ();
    assign ia.ce = ce;
    assign ia.we = we;
    assign ia.be = be;
    assign ia.addr = {9'd0, a4};
    assign ia.wdata = wd;
    assign ib.ce = ce;
    assign ib.we = we;
    assign ib.be = be;
    assign ib.addr = {9'd0, a4};
    assign ib.wdata = wd;

    sram_bw #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(13), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    sram_bw #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(13), .READ_LATENCY(2), .CLEAR_ON_RESET(1))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    int checks = 0;
    int errors = 0;

    function automatic int dep(input int k);
        return k != 0 ? 12 : 16;
    endfunction
    function automatic int lat(input int k);
        return k != 0 ? 2 : 1;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic chkb(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", n, act, exp, $time);
        end
    endtask

    // model: plain word arrays; an accepted read's result emerges lat(k) edges later
    logic [31:0] m [2][16];
    logic        flip [2][16];
    logic        pv [2][2];
    logic        pe [2][2];
    logic        pp [2][2];
    logic [31:0] pd [2][2];
    logic        e_rv [2];
    logic        e_ae [2];
    logic        e_pe [2];
    logic [31:0] e_rd [2];
    int          cnt [2];
    logic        m_acc, m_oor;
    bit          started = 0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k] = 0;
                for (int j = 0; j < 16; j++) begin
                    m[k][j] = 32'd0;
                    flip[k][j] = 1'b0;
                end
                for (int s = 0; s < 2; s++) begin
                    pv[k][s] = 1'b0;
                    pe[k][s] = 1'b0;
                    pp[k][s] = 1'b0;
                    pd[k][s] = 32'd0;
                end
                e_rv[k] = 1'b0;
                e_ae[k] = 1'b0;
                e_pe[k] = 1'b0;
                e_rd[k] = 32'd0;
            end else begin
                m_acc = cnt[k] >= dep(k) && ce;
                m_oor = int'(a4) >= dep(k);
                pv[k][1] = pv[k][0];
                pe[k][1] = pe[k][0];
                pp[k][1] = pp[k][0];
                pd[k][1] = pd[k][0];
                pv[k][0] = m_acc && !we;
                pe[k][0] = m_acc && !we && m_oor;
                pp[k][0] = m_acc && !we && !m_oor && flip[k][a4];
                pd[k][0] = m_oor ? 32'd0 : m[k][a4];
                if (m_acc && we && !m_oor) begin
                    for (int j = 0; j < 4; j++)
                        if (be[j]) m[k][a4][8*j +: 8] = wd[8*j +: 8];
                    if (be[1]) flip[k][a4] = 1'b0;
                end
                e_rv[k] = pv[k][lat(k)-1];
                if (e_rv[k]) e_rd[k] = pd[k][lat(k)-1];
                e_ae[k] = pe[k][lat(k)-1] || (m_acc && we && m_oor);
                e_pe[k] = pp[k][lat(k)-1];
                if (cnt[k] < 64) cnt[k]++;
            end
        end
        started = 1;
    end

    logic [1:0]       o_rdy, o_rv, o_ae;
    logic [1:0][31:0] o_rd;
    assign o_rdy = {ib.ready, ia.ready};
    assign o_rv  = {ib.rvalid, ia.rvalid};
    assign o_ae  = {ib.addr_err, ia.addr_err};
    assign o_rd  = {ib.rdata, ia.rdata};
`ifdef SRAM_PARITY_EN
    logic [1:0] o_pe;
    assign o_pe = {ib.parity_err, ia.parity_err};
`endif

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chkb($sformatf("ready%0d", k), o_rdy[k], !rst && cnt[k] >= dep(k));
                chkb($sformatf("rvalid%0d", k), o_rv[k], e_rv[k]);
                chk($sformatf("rdata%0d", k), o_rd[k], e_rd[k]);
                chkb($sformatf("addr_err%0d", k), o_ae[k], e_ae[k]);
`ifdef SRAM_PARITY_EN
                chkb($sformatf("parity_err%0d", k), o_pe[k], e_pe[k]);
`endif
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask
    task automatic drv(input logic c, input logic w, input logic [3:0] b, input logic [3:0] ad,
                       input logic [31:0] d);
        ce = c;
        we = w;
        be = b;
        a4 = ad;
        wd = d;
    endtask
    task automatic measure_clear();
        int na, nb;
        na = -1;
        nb = -1;
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (ia.ready && na < 0) na = i;
            if (ib.ready && nb < 0) nb = i;
        end
        chk("clear_len_a", na, 16);
        chk("clear_len_b", nb, 12);
    endtask

    initial begin
        logic [5:0] va, vb;
        drv(1'b0, 1'b0, 4'h0, 4'h0, 32'd0);
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        measure_clear();
        for (int j = 0; j < 16; j++) begin
            drv(1'b1, 1'b0, 4'hF, j[3:0], 32'd0);
            cyc();
        end
        drv(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
        cyc();
        drv(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344);
        cyc();
        drv(1'b1, 1'b0, 4'h0, 4'd3, 32'd0);
        cyc();
        chk("model_word3", m[0][3], 32'hDE22BE44);
        chk("byte_lanes_a", ia.rdata, 32'hDE22BE44);
        chkb("byte_rv_a", ia.rvalid, 1'b1);
        drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
        cyc();
        chk("byte_lanes_b", ib.rdata, 32'hDE22BE44);
        chkb("byte_rv_b", ib.rvalid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drv(1'b1, 1'b0, 4'h0, 4'(i + 1), 32'd0);
            else drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
            cyc();
            va[i] = ia.rvalid;
            vb[i] = ib.rvalid;
        end
        chk("lat1_pattern", {26'd0, va}, 32'b000111);
        chk("lat2_pattern", {26'd0, vb}, 32'b001110);
        drv(1'b1, 1'b0, 4'h0, 4'd13, 32'd0);
        cyc();
        chkb("rd13_err_a", ia.addr_err, 1'b0);
        drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
        cyc();
        chk("oor_rdata_b", ib.rdata, 32'd0);
        chkb("oor_rvalid_b", ib.rvalid, 1'b1);
        chkb("oor_rd_err_b", ib.addr_err, 1'b1);
        drv(1'b1, 1'b1, 4'hF, 4'd12, 32'hCAFEF00D);
        cyc();
        chkb("oor_wr_err_b", ib.addr_err, 1'b1);
        chkb("wr12_err_a", ia.addr_err, 1'b0);
        drv(1'b1, 1'b0, 4'h0, 4'd12, 32'd0);
        cyc();
        chk("rd12_a", ia.rdata, 32'hCAFEF00D);
        drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
        cyc();
        chk("rd12_b", ib.rdata, 32'd0);
        chkb("rd12_err_b", ib.addr_err, 1'b1);
`ifdef SRAM_PARITY_EN
        drv(1'b1, 1'b1, 4'hF, 4'd5, 32'h0F0F1234);
        cyc();
        dut_a.mem[5][9] = ~dut_a.mem[5][9];
        m[0][5][9] = ~m[0][5][9];
        flip[0][5] = 1'b1;
        drv(1'b1, 1'b0, 4'h0, 4'd5, 32'd0);
        cyc();
        chkb("parity_err_a", ia.parity_err, 1'b1);
        chkb("parity_rv_a", ia.rvalid, 1'b1);
        drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
        cyc();
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        measure_clear();
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            drv($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                4'($urandom_range(0, 15)), $urandom);
            cyc();
        end
        rst = 1'b0;
        drv(1'b0, 1'b0, 4'h0, 4'd0, 32'd0);
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
